ballot_collector: RTL and testbench
===================================

Name: ballot_collector

Overview:
- Upstream stage of the weighted vote evaluator.
- Collects individual ballots, one per clock, from three voter classes: 32 normal voters, 8 VIP voters and 1 VVIP voter.
- Assembles the ballots into the np[31:0], vip[7:0] and vvip vectors that the evaluator consumes.
- Enforces one-ballot-per-voter, rejects malformed ballots, and freezes the vectors once the poll closes by command or timeout.

Parameters:
- TIMEOUT, 1000, number of cycles in OPEN before an automatic close; legal range 2..65535.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  opens a new poll; honoured only in IDLE or CLOSED.
- close  input  1  ends the poll; honoured only in OPEN.
- ballot_valid  input  1  ballot present this cycle.
- ballot_class  input  2  0 = normal, 1 = VIP, 2 = VVIP, 3 = illegal.
- ballot_id  input  5  voter index within its class.
- ballot_yes  input  1  vote value: 1 = yes, 0 = no.
- np  output  32  normal-voter yes vector; bit i = voter i.
- vip  output  8  VIP yes vector.
- vvip  output  1  VVIP yes bit.
- ready  output  1  high in CLOSED; vectors are final and stable.
- busy  output  1  high in OPEN.
- accept  output  1  one-cycle pulse, ballot recorded.
- reject  output  1  one-cycle pulse, ballot refused.
- ballot_cnt  output  6  ballots accepted this poll, 0..41.

Behaviour:
Reset:
- State goes to IDLE.
- np, vip, vvip, ready, busy, accept, reject and ballot_cnt are all 0.
- Seen-masks are cleared and the timer is 0.
- Reset has priority over every input and aborts a poll mid-operation with no residue.

States: IDLE, OPEN, CLOSED.
- ready = (state == CLOSED).
- busy = (state == OPEN).
- Both are registered state decodes.

IDLE / CLOSED:
- start -> next cycle OPEN.
- On that same edge: np, vip, vvip, seen-masks, ballot_cnt and timer are cleared.
- ballot_valid and close are ignored, with no accept or reject pulse.
- CLOSED holds the vectors until start or reset.

OPEN, ballot qualification (evaluated when ballot_valid = 1):
- Legal means one of:
  - class 0 with any id 0..31;
  - class 1 with id 0..7;
  - class 2 with id 0.
- Class 3, or any id outside those ranges, is illegal.
- A duplicate is a legal ballot whose seen bit is already set. The first ballot wins and the vectors are unchanged.
- Legal and not duplicate:
  - set the seen bit;
  - set the vector bit to ballot_yes;
  - ballot_cnt increments;
  - accept = 1 on the next cycle.
- Illegal or duplicate: reject = 1 on the next cycle, and nothing else changes.
- accept and reject are never both 1.
- Latency is one cycle: vector, count and pulse all update on the edge that samples the ballot.
- A no vote (ballot_yes = 0) is still recorded in the seen-mask and counted.

OPEN, timer and exit:
- The timer counts 0..TIMEOUT-1, starting from 0 on entry to OPEN.
- Exit to CLOSED occurs when close = 1 or the timer equals TIMEOUT-1.
- A ballot sampled in the same cycle as close or timeout is still processed, then the block closes.
- start in OPEN is ignored.
- 41 accepted ballots do not auto-close. Every further ballot is a duplicate and is rejected; ballot_cnt saturates naturally at 41.

Width rules:
- ballot_cnt is 6-bit and cannot overflow.
- The timer is 16-bit.

Test Plan:
- Scenario 1: reset, start, then 32 class-0 ballots with id 0..31 and ballot_yes = 1, then VIP ids 0..4 yes, VIP ids 5..7 no, VVIP no, then close.
  Required: 41 accept pulses; np = 32'hFFFF_FFFF, vip = 8'h1F, vvip = 0, ballot_cnt = 41; ready = 1 two cycles after close.
- Scenario 2: in OPEN, class 0 id 3 yes, then class 0 id 3 no.
  Required: the second ballot pulses reject; np[3] stays 1; ballot_cnt = 1.
- Scenario 3: illegal ballots: class 1 id 8, class 2 id 1, class 3 id 0.
  Required: each pulses reject; vectors stay 0; ballot_cnt = 0.
- Scenario 4: TIMEOUT = 5, start, no ballots.
  Required: ready rises exactly 5 cycles after busy rises. A ballot at timeout is accepted and appears in the frozen vectors.
- Scenario 5: ballots after close, and start while OPEN.
  Required: ballots in CLOSED produce no pulse and no change; start in OPEN leaves ballot_cnt intact; start in CLOSED clears np/vip/vvip to 0 and ballot_cnt to 0.
- Scenario 6: reset asserted mid-poll after 10 accepts.
  Required: next cycle all outputs are 0 and state is IDLE; a subsequent start plus class 0 id 0 is accepted; ballot_cnt = 1.

Source files
------------

// File: rtl/ballot_collector_if.sv
// Ballot bus and result vectors shared between the ballot source and the collector.
interface ballot_collector_if;
    logic        start;
    logic        close;
    logic        ballot_valid;
    logic [1:0]  ballot_class;
    logic [4:0]  ballot_id;
    logic        ballot_yes;
    logic [31:0] np;
    logic [7:0]  vip;
    logic        vvip;
    logic        ready;
    logic        busy;
    logic        accept;
    logic        reject;
    logic [5:0]  ballot_cnt;

    modport master (
        output start, close, ballot_valid, ballot_class, ballot_id, ballot_yes,
        input  np, vip, vvip, ready, busy, accept, reject, ballot_cnt
    );

    modport slave (
        input  start, close, ballot_valid, ballot_class, ballot_id, ballot_yes,
        output np, vip, vvip, ready, busy, accept, reject, ballot_cnt
    );
endinterface

// File: rtl/ballot_collector.sv
// Ballot collector: gathers one ballot per clock from 32 normal, 8 VIP and
// 1 VVIP voter, enforces one ballot per voter and freezes the yes-vectors
// once the poll closes by command or timeout.
module ballot_collector #(
    parameter int TIMEOUT = 1000
) (
    input logic               clk,
    input logic               reset,
    ballot_collector_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OPEN, CLOSED} state_t;

    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [31:0] np_q, seen_np;
    logic [7:0]  vip_q, seen_vip;
    logic        vvip_q, seen_vvip;
    logic [5:0]  cnt;
    logic [15:0] timer;
    logic        accept_q, reject_q, ready_q, busy_q;
    logic        legal, dup, take, refuse, clear, expire;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state plus per-cycle ballot qualification
    always_comb begin
        state_next = state;
        legal      = 1'b0;
        dup        = 1'b0;
        take       = 1'b0;
        refuse     = 1'b0;
        clear      = 1'b0;
        expire     = 1'b0;
        case (bus.ballot_class)
            2'd0: begin legal = 1'b1;                    dup = seen_np[bus.ballot_id];       end
            2'd1: begin legal = (bus.ballot_id < 5'd8);  dup = seen_vip[bus.ballot_id[2:0]]; end
            2'd2: begin legal = (bus.ballot_id == 5'd0); dup = seen_vvip;                    end
            default: begin legal = 1'b0;                 dup = 1'b0;                         end
        endcase
        case (state)
            OPEN: begin
                if (bus.ballot_valid) begin
                    take   = legal && !dup;
                    refuse = !(legal && !dup);
                end
                // the ballot sampled on the closing edge is still processed above
                expire = bus.close || (timer == LAST);
                if (expire) state_next = CLOSED;
            end
            default: begin
                if (bus.start) begin
                    clear      = 1'b1;
                    state_next = OPEN;
                end
            end
        endcase
    end

    // Vectors, seen-masks, counter, timer and registered status/pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            np_q      <= '0;
            vip_q     <= '0;
            vvip_q    <= 1'b0;
            seen_np   <= '0;
            seen_vip  <= '0;
            seen_vvip <= 1'b0;
            cnt       <= '0;
            timer     <= '0;
            accept_q  <= 1'b0;
            reject_q  <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            accept_q <= take;
            reject_q <= refuse;
            ready_q  <= (state_next == CLOSED);
            busy_q   <= (state_next == OPEN);
            if (clear) begin
                np_q      <= '0;
                vip_q     <= '0;
                vvip_q    <= 1'b0;
                seen_np   <= '0;
                seen_vip  <= '0;
                seen_vvip <= 1'b0;
                cnt       <= '0;
                timer     <= '0;
            end else begin
                if (take) begin
                    case (bus.ballot_class)
                        2'd0: begin
                            np_q[bus.ballot_id]    <= bus.ballot_yes;
                            seen_np[bus.ballot_id] <= 1'b1;
                        end
                        2'd1: begin
                            vip_q[bus.ballot_id[2:0]]    <= bus.ballot_yes;
                            seen_vip[bus.ballot_id[2:0]] <= 1'b1;
                        end
                        default: begin
                            vvip_q    <= bus.ballot_yes;
                            seen_vvip <= 1'b1;
                        end
                    endcase
                    // at most 41 distinct voters exist, so 6 bits never wrap
                    cnt <= cnt + 6'd1;
                end
                if (state == OPEN && !expire) timer <= timer + 16'd1;
            end
        end
    end

    assign bus.np         = np_q;
    assign bus.vip        = vip_q;
    assign bus.vvip       = vvip_q;
    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;
    assign bus.accept     = accept_q;
    assign bus.reject     = reject_q;
    assign bus.ballot_cnt = cnt;
endmodule

// File: tb/tb_ballot_collector.sv
// Self-checking bench for ballot_collector: directed scenarios plus random
// ballots, all checked every cycle against a voter-level reference model.
module tb_ballot_collector;
    localparam int TO = 48;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ballot_collector_if bus ();
    ballot_collector #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct packed {
        logic [31:0] np;
        logic [7:0]  vip;
        logic        vvip;
        logic        ready;
        logic        busy;
        logic        accept;
        logic        reject;
        logic [5:0]  cnt;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   acc_seen = 0;
    int   cyc = 0;

    // Reference model: a poll is a set of 41 voters, each seen or not, with a vote.
    bit m_open, m_closed;
    bit m_seen[41];
    bit m_yes[41];
    int m_cnt, m_t;
    bit m_acc, m_rej;

    function automatic int voter(int c, int id);
        return (c == 0) ? id : (c == 1) ? 32 + id : 40;
    endfunction

    function automatic bit is_legal(int c, int id);
        return (c == 0) || (c == 1 && id < 8) || (c == 2 && id == 0);
    endfunction

    task automatic model_edge(bit r, bit st, bit cl, bit v, int c, int id, bit y);
        m_acc = 0; m_rej = 0;
        if (r) begin
            m_open = 0; m_closed = 0; m_cnt = 0; m_t = 0;
            foreach (m_seen[i]) begin m_seen[i] = 0; m_yes[i] = 0; end
        end else if (!m_open) begin
            if (st) begin
                m_open = 1; m_closed = 0; m_cnt = 0; m_t = 0;
                foreach (m_seen[i]) begin m_seen[i] = 0; m_yes[i] = 0; end
            end
        end else begin
            if (v) begin
                if (is_legal(c, id) && !m_seen[voter(c, id)]) begin
                    m_seen[voter(c, id)] = 1;
                    m_yes[voter(c, id)]  = y;
                    m_cnt++;
                    m_acc = 1;
                end else m_rej = 1;
            end
            if (cl || m_t == TO - 1) begin m_open = 0; m_closed = 1; end
            else m_t++;
        end
    endtask

    function automatic obs_t model_obs();
        obs_t e;
        for (int i = 0; i < 32; i++) e.np[i] = m_yes[i];
        for (int i = 0; i < 8; i++)  e.vip[i] = m_yes[32 + i];
        e.vvip   = m_yes[40];
        e.ready  = m_closed;
        e.busy   = m_open;
        e.accept = m_acc;
        e.reject = m_rej;
        e.cnt    = 6'(m_cnt);
        return e;
    endfunction

    // One clock of stimulus; expected state after the edge goes to the scoreboard.
    task automatic step(bit r, bit st, bit cl, bit v, int c, int id, bit y);
        reset = r; bus.start = st; bus.close = cl; bus.ballot_valid = v;
        bus.ballot_class = 2'(c); bus.ballot_id = 5'(id); bus.ballot_yes = y;
        @(posedge clk);
        model_edge(r, st, cl, v, c, id, y);
        exp_q.push_back(model_obs());
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ballot(int c, int id, bit y);
        step(0, 0, 0, 1, c, id, y);
    endtask

    task automatic check(string name, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Monitor: compare the DUT against the oldest expected observation.
    always @(negedge clk) begin
        obs_t e, a;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.np, bus.vip, bus.vvip, bus.ready, bus.busy,
                 bus.accept, bus.reject, bus.ballot_cnt};
            if (bus.accept === 1'b1) acc_seen++;
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL scoreboard cycle=%0d got np=%h vip=%h vvip=%b rdy=%b busy=%b acc=%b rej=%b cnt=%0d want np=%h vip=%h vvip=%b rdy=%b busy=%b acc=%b rej=%b cnt=%0d",
                         cyc, a.np, a.vip, a.vvip, a.ready, a.busy, a.accept, a.reject, a.cnt,
                         e.np, e.vip, e.vvip, e.ready, e.busy, e.accept, e.reject, e.cnt);
            end
        end
    end

    initial begin
        int a0, n;
        // Scenario 1: full electorate
        step(1, 0, 0, 0, 0, 0, 0);
        check("reset_cnt", int'(bus.ballot_cnt), 0);
        check("reset_np", int'(bus.np != 0), 0);
        step(0, 1, 0, 0, 0, 0, 0);
        a0 = acc_seen;
        for (int i = 0; i < 32; i++) ballot(0, i, 1);
        for (int i = 0; i < 8; i++) ballot(1, i, i < 5);
        ballot(2, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        idle();
        check("s1_accepts", acc_seen - a0, 41);
        check("s1_np_full", int'(bus.np == 32'hFFFF_FFFF), 1);
        check("s1_vip", int'(bus.vip), 8'h1F);
        check("s1_vvip", int'(bus.vvip), 0);
        check("s1_cnt", int'(bus.ballot_cnt), 41);
        check("s1_ready", int'(bus.ready), 1);
        // Scenario 2: duplicate
        step(0, 1, 0, 0, 0, 0, 0);
        ballot(0, 3, 1);
        ballot(0, 3, 0);
        check("s2_reject", int'(bus.reject), 1);
        idle();
        check("s2_np3", int'(bus.np[3]), 1);
        check("s2_cnt", int'(bus.ballot_cnt), 1);
        // Scenario 3: illegal ballots
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        ballot(1, 8, 1);
        ballot(2, 1, 1);
        ballot(3, 0, 1);
        check("s3_reject", int'(bus.reject), 1);
        idle();
        check("s3_cnt", int'(bus.ballot_cnt), 0);
        check("s3_vec", int'(bus.np != 0 || bus.vip != 0 || bus.vvip != 0), 0);
        // Scenario 4: timeout, with a ballot on the final cycle
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        n = 0;
        while (!bus.ready && n < 200) begin idle(); n++; end
        check("s4_timeout_cycles", n, TO);
        step(0, 1, 0, 0, 0, 0, 0);
        repeat (TO - 1) idle();
        ballot(0, 17, 1);
        check("s4_late_accept", int'(bus.accept), 1);
        check("s4_late_ready", int'(bus.ready), 1);
        check("s4_late_np17", int'(bus.np[17]), 1);
        // Scenario 5: ballots in CLOSED, start in OPEN, start in CLOSED
        ballot(0, 5, 1);
        check("s5_closed_nopulse", int'(bus.accept | bus.reject), 0);
        check("s5_closed_np5", int'(bus.np[5]), 0);
        step(0, 1, 0, 0, 0, 0, 0);
        ballot(0, 1, 1);
        ballot(1, 2, 1);
        step(0, 1, 0, 0, 0, 0, 0);
        check("s5_start_open_cnt", int'(bus.ballot_cnt), 2);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        check("s5_start_closed_cnt", int'(bus.ballot_cnt), 0);
        check("s5_start_closed_vec", int'(bus.np != 0 || bus.vip != 0), 0);
        // Scenario 6: reset mid-poll
        for (int i = 0; i < 10; i++) ballot(0, i, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        check("s6_rst_cnt", int'(bus.ballot_cnt), 0);
        check("s6_rst_busy", int'(bus.busy | bus.ready), 0);
        step(0, 1, 0, 0, 0, 0, 0);
        ballot(0, 0, 1);
        check("s6_accept", int'(bus.accept), 1);
        check("s6_cnt", int'(bus.ballot_cnt), 1);
        // Random traffic
        for (int k = 0; k < 2000; k++) begin
            bit r, st, cl, v, y;
            int c, id;
            r  = ($urandom_range(0, 199) == 0);
            st = ($urandom_range(0, 19) == 0);
            cl = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 9) < 7);
            c  = $urandom_range(0, 3);
            id = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 31);
            y  = $urandom_range(0, 1);
            step(r, st, cl, v, c, id, y);
        end
        idle();
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
